// File: rtl/jrb8_disp_pkg.sv
// rtl/jrb8_disp_pkg.sv - shared types and constants for the JRB8 output display
package jrb8_disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    localparam int NUM_DIGITS = 3;

    // Segment bus order is {dp,g,f,e,d,c,b,a}; entry i encodes decimal digit i.
    localparam logic [7:0]       SEG_BLANK = 8'h00;
    localparam logic [9:0][7:0]  SEG_TABLE = {
        8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
        8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

endpackage

// File: rtl/jrb8_seg_decode.sv
// rtl/jrb8_seg_decode.sv - BCD digit to 7-segment decode with blanking
module jrb8_seg_decode
    import jrb8_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i && (digit_i <= 4'd9)) begin
            seg_o = SEG_TABLE[digit_i];
        end
    end

endmodule

// File: rtl/jrb8_out_display.sv
// rtl/jrb8_out_display.sv - binary-to-BCD converter and 3-digit scanned display (JRB8_DISP_LZB_EN: leading-zero blanking)
module jrb8_out_display
    import jrb8_disp_pkg::*;
#(
    parameter logic [23:0] DWELL_COUNT = 24'd10_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value_in,
    input  logic       load,
    output logic       busy,
    output logic [7:0] seg_out,
    output logic [2:0] dig_en
);

    state_e      state_q;
    logic [17:0] shift_q;
    logic [17:0] shift_d;
    logic [3:0]  iter_q;
    logic [1:0]  hun_q;
    logic [3:0]  ten_q;
    logic [3:0]  one_q;
    logic [23:0] dwell_q;
    logic [1:0]  dig_idx_q;

    logic [3:0]  sel_digit;
    logic        sel_blank;
    logic        blank_hun;
    logic        blank_ten;

    // Hundreds never reaches 5 for 8-bit input, so only ones and tens need the +3 fixup.
    always_comb begin
        shift_d = shift_q;
        if (shift_q[11:8] >= 4'd5) begin
            shift_d[11:8] = shift_q[11:8] + 4'd3;
        end
        if (shift_q[15:12] >= 4'd5) begin
            shift_d[15:12] = shift_q[15:12] + 4'd3;
        end
    end

    // rst_n is active-high here, matching the surrounding codebase.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            iter_q  <= '0;
            hun_q   <= '0;
            ten_q   <= '0;
            one_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        shift_q <= {10'd0, value_in};
                        iter_q  <= '0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    shift_q <= shift_d << 1;
                    iter_q  <= iter_q + 4'd1;
                    if (iter_q == 4'd7) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    hun_q   <= shift_q[17:16];
                    ten_q   <= shift_q[15:12];
                    one_q   <= shift_q[11:8];
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            dwell_q   <= '0;
            dig_idx_q <= '0;
        end else if (dwell_q == DWELL_COUNT - 24'd1) begin
            dwell_q   <= '0;
            dig_idx_q <= (dig_idx_q == 2'(NUM_DIGITS - 1)) ? 2'd0 : dig_idx_q + 2'd1;
        end else begin
            dwell_q <= dwell_q + 24'd1;
        end
    end

`ifdef JRB8_DISP_LZB_EN
    assign blank_hun = (hun_q == 2'd0);
    assign blank_ten = blank_hun && (ten_q == 4'd0);
`else
    assign blank_hun = 1'b0;
    assign blank_ten = 1'b0;
`endif

    always_comb begin
        sel_digit = 4'd0;
        sel_blank = 1'b1;
        dig_en    = 3'b000;
        case (dig_idx_q)
            2'd0: begin
                sel_digit = one_q;
                sel_blank = 1'b0;
                dig_en    = 3'b001;
            end
            2'd1: begin
                sel_digit = ten_q;
                sel_blank = blank_ten;
                dig_en    = 3'b010;
            end
            2'd2: begin
                sel_digit = {2'b00, hun_q};
                sel_blank = blank_hun;
                dig_en    = 3'b100;
            end
            default: ;
        endcase
    end

    jrb8_seg_decode u_seg_decode (
        .digit_i (sel_digit),
        .blank_i (sel_blank),
        .seg_o   (seg_out)
    );

endmodule

// File: tb/tb_jrb8_out_display.sv
// tb/tb_jrb8_out_display.sv - scoreboard bench for jrb8_out_display
module tb_jrb8_out_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] value_in = 8'd0;
    logic       load = 1'b0;
    logic       busy;
    logic [7:0] seg_out;
    logic [2:0] dig_en;
    logic       busy_s;
    logic [7:0] seg_out_s;
    logic [2:0] dig_en_s;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    jrb8_out_display #(.DWELL_COUNT(24'd1)) dut (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
        .busy(busy), .seg_out(seg_out), .dig_en(dig_en)
    );

    jrb8_out_display #(.DWELL_COUNT(24'd4)) dut_scan (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
        .busy(busy_s), .seg_out(seg_out_s), .dig_en(dig_en_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
            4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
            8: return 8'h7F;  9: return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [23:0] exp_segs(input int v);
        int h, t, o;
        logic [7:0] sh, st;
        h = v / 100; t = (v / 10) % 10; o = v % 10;
        sh = seg_of(h); st = seg_of(t);
`ifdef JRB8_DISP_LZB_EN
        if (h == 0) sh = 8'h00;
        if (h == 0 && t == 0) st = 8'h00;
`endif
        return {sh, st, seg_of(o)};
    endfunction

    function automatic logic [7:0] blank_zero_seg();
`ifdef JRB8_DISP_LZB_EN
        return 8'h00;
`else
        return 8'h3F;
`endif
    endfunction

    // Caller sits at a negedge; load is sampled on the next posedge.
    task automatic do_load(input int v, input bit push);
        value_in = 8'(v);
        load = 1'b1;
        if (push) exp_q.push_back(v);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        if (busy) chk("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    // Monitor: each commit (busy falling outside reset) shows a new number; with
    // DWELL_COUNT=1 three consecutive cycles cover all digit positions.
    initial begin : monitor
        logic busy_prev;
        logic [7:0] sh, st, so;
        logic [2:0] seen;
        int v;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_prev && !busy && !rst_n) begin
                seen = 3'b000; sh = 8'hxx; st = 8'hxx; so = 8'hxx;
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clk);
                    case (dig_en)
                        3'b001: begin so = seg_out; seen[0] = 1'b1; end
                        3'b010: begin st = seg_out; seen[1] = 1'b1; end
                        3'b100: begin sh = seg_out; seen[2] = 1'b1; end
                        default: seen = 3'b000;
                    endcase
                end
                chk("mon_digit_cover", 32'(seen), 32'b111);
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected_commit", 32'(exp_q.size()), 32'd1);
                end else begin
                    v = exp_q.pop_front();
                    chk($sformatf("display_value_%0d", v), {8'h00, sh, st, so}, {8'h00, exp_segs(v)});
                end
            end
            busy_prev = busy;
        end
    end

    initial begin : watchdog
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int cnt, t0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dig_en", 32'(dig_en), 32'b001);
        chk("rst_seg", 32'(seg_out), 32'h3F);
        chk("rst_scan_dig_en", 32'(dig_en_s), 32'b001);
        rst_n = 1'b0;
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    chk($sformatf("scan_k%0d", k), 32'(dig_en_s), 32'(3'b001 << ((k / 4) % 3)));
                    @(negedge clk);
                end
            end
            begin
                @(negedge clk);
                chk("rst_ten_en", 32'(dig_en), 32'b010);
                chk("rst_ten_seg", 32'(seg_out), 32'(blank_zero_seg()));
                @(negedge clk);
                chk("rst_hun_en", 32'(dig_en), 32'b100);
                chk("rst_hun_seg", 32'(seg_out), 32'(blank_zero_seg()));
                @(negedge clk);
                do_load(77, 1'b1);
                wait_idle(cnt);
            end
        join

        do_load(255, 1'b1);
        wait_idle(cnt);
        chk("busy_cycles_255", 32'(cnt), 32'd9);
        repeat (4) @(negedge clk);

        // Requests at N+3 and N+9 (COMMIT) are dropped; the one at N+10 is taken.
        do_load(123, 1'b1);
        repeat (2) @(negedge clk);
        do_load(45, 1'b0);
        repeat (5) @(negedge clk);
        value_in = 8'd45;
        load = 1'b1;
        @(negedge clk);
        chk("drop_busy_at_commit", 32'(busy), 32'd0);
        do_load(45, 1'b1);
        wait_idle(cnt);
        repeat (4) @(negedge clk);

        do_load(88, 1'b1);
        wait_idle(cnt);
        repeat (4) @(negedge clk);
        do_load(200, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dig_en", 32'(dig_en), 32'b001);
        chk("abort_seg", 32'(seg_out), 32'h3F);
        @(negedge clk);
        rst_n = 1'b0;
        chk("abort_ones_seg", 32'(seg_out), 32'h3F);
        @(negedge clk);
        chk("abort_ten_seg", 32'(seg_out), 32'(blank_zero_seg()));
        @(negedge clk);
        chk("abort_hun_seg", 32'(seg_out), 32'(blank_zero_seg()));
        repeat (15) @(negedge clk);
        chk("abort_busy_after", 32'(busy), 32'd0);

        t0 = cycle;
        for (int v = 0; v < 256; v++) begin
            do_load(v, 1'b1);
            wait_idle(cnt);
        end
        chk("sweep_cycles", 32'(cycle - t0), 32'd2560);
        repeat (6) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
